ahb_decoder_ctrl: RTL and testbench

- AHB address decoder and data-phase controller for the ROM/RAM read-data/response multiplexer.
- Decodes each address-phase transfer to a ROM or RAM slave select.
- Registers the data-phase mux select (muxsel) for the multiplexer.
- Acts as the built-in default slave: unmapped accesses and ROM writes receive a two-cycle AHB ERROR.
- Sits between the master's address bus, the two slaves and the multiplexer; drives the final hready/hresp to the master.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_addr_decode.sv | 32 +++
 rtl/ahb_decoder_ctrl.sv | 123 ++++++++++++
 tb/tb_ahb_decoder_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB constants, default region map and the data-phase state type
// used by the ROM/RAM decoder/controller.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK_DEFAULT = 32'hFFFF_0000;
    localparam logic [31:0] RAM_BASE_DEFAULT = 32'h2000_0000;
    localparam logic [31:0] RAM_MASK_DEFAULT = 32'hFFFF_0000;

    typedef enum logic [2:0] {
        DP_NONE = 3'd0,
        DP_ROM  = 3'd1,
        DP_RAM  = 3'd2,
        DP_ERR1 = 3'd3,
        DP_ERR2 = 3'd4
    } dp_state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address-phase decode: ROM/RAM slave selects and the
// default-slave error request (unmapped address or write to ROM).
module ahb_addr_decode
    import ahb_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter logic [31:0] ROM_MASK = ROM_MASK_DEFAULT,
    parameter logic [31:0] RAM_BASE = RAM_BASE_DEFAULT,
    parameter logic [31:0] RAM_MASK = RAM_MASK_DEFAULT
) (
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    output logic        hsel_rom,
    output logic        hsel_ram,
    output logic        err_req
);

    logic valid;
    logic rom_hit;
    logic ram_hit;

    assign valid   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign rom_hit = (haddr & ROM_MASK) == ROM_BASE;
    assign ram_hit = (haddr & RAM_MASK) == RAM_BASE;

    // ROM takes priority when the regions overlap
    assign hsel_rom = valid & rom_hit & ~hwrite;
    assign hsel_ram = valid & ram_hit & ~rom_hit;
    assign err_req  = valid & ~hsel_rom & ~hsel_ram;

endmodule

// File: rtl/ahb_decoder_ctrl.sv
// AHB ROM/RAM decoder, data-phase mux select and built-in default slave.
// Define ERR_COUNT_EN to build the saturating default-slave error counter.
//
// state   | meaning
// DP_NONE | no data phase pending, zero-wait OKAY
// DP_ROM  | ROM data phase, hready/hresp from the mux
// DP_RAM  | RAM data phase, hready/hresp from the mux
// DP_ERR1 | first ERROR cycle, hready low
// DP_ERR2 | second ERROR cycle, hready high
module ahb_decoder_ctrl
    import ahb_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter logic [31:0] ROM_MASK = ROM_MASK_DEFAULT,
    parameter logic [31:0] RAM_BASE = RAM_BASE_DEFAULT,
    parameter logic [31:0] RAM_MASK = RAM_MASK_DEFAULT
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic        hready_mux,
    input  logic        hresp_mux,
    output logic        hsel_rom,
    output logic        hsel_ram,
    output logic        muxsel,
    output logic        hready,
    output logic        hresp,
    output logic [15:0] err_count
);

    dp_state_t state_q, state_d;
    logic      muxsel_q, muxsel_d;
    logic      err_req;

    ahb_addr_decode #(
        .ROM_BASE (ROM_BASE),
        .ROM_MASK (ROM_MASK),
        .RAM_BASE (RAM_BASE),
        .RAM_MASK (RAM_MASK)
    ) u_decode (
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsel_rom (hsel_rom),
        .hsel_ram (hsel_ram),
        .err_req  (err_req)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= DP_NONE;
            muxsel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            muxsel_q <= muxsel_d;
        end
    end

    // An address phase is taken whenever the master sees hready high,
    // including the last cycle of the error response.
    always_comb begin
        state_d  = state_q;
        muxsel_d = muxsel_q;
        if (hready) begin
            muxsel_d = hsel_rom;
            if (hsel_rom) begin
                state_d = DP_ROM;
            end else if (hsel_ram) begin
                state_d = DP_RAM;
            end else if (err_req) begin
                state_d = DP_ERR1;
            end else begin
                state_d = DP_NONE;
            end
        end else if (state_q == DP_ERR1) begin
            state_d = DP_ERR2;
        end
    end

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (state_q)
            DP_ROM, DP_RAM: begin
                hready = hready_mux;
                hresp  = hresp_mux;
            end
            DP_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            DP_ERR2: begin
                hready = 1'b1;
                hresp  = HRESP_ERROR;
            end
            default: begin
                hready = 1'b1;
                hresp  = HRESP_OKAY;
            end
        endcase
    end

    assign muxsel = muxsel_q;

`ifdef ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            err_cnt_q <= 16'h0000;
        end else if (hready && err_req && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_decoder_ctrl.sv
// Directed plus randomized bench for ahb_decoder_ctrl against a
// transfer-level model of the decoder and default slave.
module tb_ahb_decoder_ctrl;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hready_mux;
    logic        hresp_mux;
    logic        hsel_rom;
    logic        hsel_ram;
    logic        muxsel;
    logic        hready;
    logic        hresp;
    logic [15:0] err_count;

    ahb_decoder_ctrl dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hready_mux (hready_mux),
        .hresp_mux  (hresp_mux),
        .hsel_rom   (hsel_rom),
        .hsel_ram   (hsel_ram),
        .muxsel     (muxsel),
        .hready     (hready),
        .hresp      (hresp),
        .err_count  (err_count)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the pending data phase is, not how the RTL encodes it.
    bit m_known     = 1'b0;
    bit m_slave     = 1'b0;   // a ROM/RAM data phase is in flight
    bit m_rom       = 1'b0;   // last accepted transfer went to ROM
    int m_err_left  = 0;      // ERROR cycles still to present (2, 1 or 0)
    int m_errs      = 0;

    logic o_rom, o_ram, o_mux, o_rdy, o_resp;
    logic [15:0] o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model_decode(input logic [31:0] a, input logic [1:0] t, input logic w,
                                         output bit rom, output bit ram, output bit err);
        bit valid, in_rom, in_ram;
        valid  = (t == 2'd2) || (t == 2'd3);
        in_rom = a < 32'h0001_0000;
        in_ram = (a >= 32'h2000_0000) && (a < 32'h2001_0000);
        rom    = valid && in_rom && !w;
        ram    = valid && in_ram && !in_rom;
        err    = valid && !rom && !ram;
    endfunction

    function automatic bit exp_ready(input bit rmux);
        if (m_err_left == 2) return 1'b0;
        if (m_err_left == 1) return 1'b1;
        if (m_slave) return rmux;
        return 1'b1;
    endfunction

    function automatic bit exp_resp(input bit pmux);
        if (m_err_left != 0) return 1'b1;
        if (m_slave) return pmux;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef ERR_COUNT_EN
        return (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic cyc(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic rmux, input logic pmux, input logic rst);
        bit rom, ram, err, rdy;
        @(negedge hclk);
        haddr = a; htrans = t; hwrite = w;
        hready_mux = rmux; hresp_mux = pmux; hreset = rst;
        #1;
        o_rom = hsel_rom; o_ram = hsel_ram; o_mux = muxsel;
        o_rdy = hready; o_resp = hresp; o_cnt = err_count;
        model_decode(a, t, w, rom, ram, err);
        rdy = exp_ready(rmux);
        if (m_known) begin
            chk("hsel_rom", 32'(o_rom), 32'(rom));
            chk("hsel_ram", 32'(o_ram), 32'(ram));
            chk("muxsel", 32'(o_mux), 32'(m_rom));
            chk("hready", 32'(o_rdy), 32'(rdy));
            chk("hresp", 32'(o_resp), 32'(exp_resp(pmux)));
            chk("err_count", 32'(o_cnt), 32'(exp_cnt()));
        end
        @(posedge hclk);
        if (rst) begin
            m_known = 1'b1; m_slave = 1'b0; m_rom = 1'b0; m_err_left = 0; m_errs = 0;
        end else if (rdy) begin
            m_slave    = rom || ram;
            m_rom      = rom;
            m_err_left = err ? 2 : 0;
            if (err) m_errs++;
        end else if (m_err_left == 2) begin
            m_err_left = 1;
        end
    endtask

    localparam logic [1:0] IDL = 2'd0, NSQ = 2'd2, SQ = 2'd3;

    initial begin
        logic [31:0] a;
        hreset = 1'b1; haddr = '0; htrans = IDL; hwrite = 1'b0;
        hready_mux = 1'b1; hresp_mux = 1'b0;

        // Reset
        cyc(32'h0, IDL, 0, 1, 0, 1);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("rst_hready", 32'(o_rdy), 32'd1);
        chk("rst_hresp", 32'(o_resp), 32'd0);
        chk("rst_muxsel", 32'(o_mux), 32'd0);
        chk("rst_errcnt", 32'(o_cnt), 32'd0);

        // ROM read with two wait states
        cyc(32'h0000_0010, NSQ, 0, 1, 0, 0);
        chk("rom_hsel", 32'(o_rom), 32'd1);
        cyc(32'h0, IDL, 0, 0, 0, 0);
        chk("rom_ws1_mux", 32'(o_mux), 32'd1);
        chk("rom_ws1_rdy", 32'(o_rdy), 32'd0);
        cyc(32'h0, IDL, 0, 0, 0, 0);
        chk("rom_ws2_rdy", 32'(o_rdy), 32'd0);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("rom_done_rdy", 32'(o_rdy), 32'd1);

        // RAM back-to-back
        cyc(32'h2000_0000, NSQ, 1, 1, 0, 0);
        chk("ram_w_hsel", 32'(o_ram), 32'd1);
        cyc(32'h2000_0004, SQ, 0, 1, 0, 0);
        chk("ram_r_hsel", 32'(o_ram), 32'd1);
        chk("ram_r_mux", 32'(o_mux), 32'd0);
        chk("ram_r_rdy", 32'(o_rdy), 32'd1);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("ram_end_mux", 32'(o_mux), 32'd0);

        // Unmapped
        cyc(32'h4000_0000, NSQ, 0, 1, 0, 0);
        chk("unm_hsel", 32'({o_rom, o_ram}), 32'd0);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("unm_err1", 32'({o_rdy, o_resp}), 32'b01);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("unm_err2", 32'({o_rdy, o_resp}), 32'b11);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("unm_after", 32'({o_rdy, o_resp}), 32'b10);
`ifdef ERR_COUNT_EN
        chk("unm_cnt", 32'(o_cnt), 32'd1);
`endif

        // ROM write
        cyc(32'h0000_0000, NSQ, 1, 1, 0, 0);
        chk("romw_hsel", 32'(o_rom), 32'd0);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("romw_err1", 32'({o_rdy, o_resp}), 32'b01);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("romw_err2", 32'({o_rdy, o_resp}), 32'b11);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("romw_idle", 32'({o_rdy, o_resp}), 32'b10);

        // Reset in the middle of a RAM wait state
        cyc(32'h2000_0100, NSQ, 0, 1, 0, 0);
        cyc(32'h0, IDL, 0, 0, 0, 1);
        chk("mid_wait_rdy", 32'(o_rdy), 32'd0);
        cyc(32'h0000_0010, NSQ, 0, 0, 0, 0);
        chk("post_rst_rdy", 32'(o_rdy), 32'd1);
        chk("post_rst_hsel", 32'(o_rom), 32'd1);
        cyc(32'h0, IDL, 0, 1, 0, 0);
        chk("post_rst_mux", 32'(o_mux), 32'd1);

        // Randomized traffic, including region edges and slave errors
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: a = $urandom_range(0, 32'h0000_FFFF);
                1: a = 32'h2000_0000 + $urandom_range(0, 32'h0000_FFFF);
                2: a = $urandom;
                3: begin
                    case ($urandom_range(0, 4))
                        0: a = 32'h0000_FFFF;
                        1: a = 32'h0001_0000;
                        2: a = 32'h1FFF_FFFC;
                        3: a = 32'h2000_FFFC;
                        default: a = 32'h2001_0000;
                    endcase
                end
                default: a = 32'hFFFF_FFF0;
            endcase
            cyc(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
